filt_sched: RTL and testbench
=============================

# filt_sched

Time-multiplexed glitch-filter scheduler: shares one filter engine across N asynchronous input channels instead of instantiating one filter per channel. A prescaler generates a sample tick. Each tick starts a sweep that visits every channel once, one channel per clock. For each visited channel the block loads that channel's saved filter context, advances it by one step and writes it back. The block sits between raw pin inputs and the control logic that consumes debounced levels and edge events.

## Interface
- `N`, default 4 — number of channels, 1..16.
- `DIV`, default 100 — prescaler period in clk cycles. Must be ≥ N+1.
- `THR`, default 9 — count threshold, 0..14. A pending level is accepted once cnt > THR.
- `clk`  in  1 — clock; all flops on rising edge.
- `rst_n`  in  1 — synchronous reset, active low.
- `en`  in  1 — prescaler run enable.
- `i`  in  N — raw asynchronous channel inputs.
- `y`  out  N — filtered levels, registered.
- `chg`  out  N — one-cycle pulse on `y[k]` change.
- `busy`  out  1 — sweep in progress.
- `done`  out  1 — one-cycle pulse in the cycle that processes the last channel.
- `ovr`  out  1 — sticky: a tick occurred while busy.

## Operation
- Input sync: `i` passes through a 2-flop synchronizer before use. The engine only ever sees `is`, the synchronized value.
- Prescaler `pre`:
  - Counts 0..DIV-1 while `en`=1 and wraps to 0.
  - `tick` = `en` & (`pre`==DIV-1).
  - `en`=0 freezes `pre` at its current value (no clear).
- Scheduler FSM, states IDLE and SCAN:
  - IDLE, tick: go to SCAN with `ch`=0.
  - SCAN: process channel `ch`, then increment `ch`. When `ch`==N-1, return to IDLE.
  - An in-progress sweep always completes, even if `en` drops.
- Tick while in SCAN: the tick is dropped, no sweep restarts, and `ovr` is set to 1 until reset.
- Per-channel context: fst[k] (2 bits: Z0=0, Z1=1, E0=2, E1=3) and cnt[k] (4 bits).
- Filter step for channel k, using the old fst/cnt and `is[k]`:
  - Z0: go to Z1 if is=1.
  - Z1: go to E0 if cnt>THR; else go to Z0 if is=0. The cnt check has priority over is.
  - E0: go to E1 if is=0.
  - E1: go to Z0 if cnt>THR; else go to E0 if is=1.
  - cnt ← cnt+1 in Z1/E1, else 0. cnt cannot exceed THR+1, so there is no wrap.
  - y ← 0 if old state Z0; y ← 1 if old state E0; otherwise hold.
- `chg[k]` is 1 in exactly the cycle `y[k]` first shows a new value.
- Channels not being processed hold fst, cnt and y unchanged.
- Reset (rst_n=0 at any clock edge, including mid-sweep):
  - Every context goes to Z0 / cnt 0.
  - `pre`=0, `ch`=0, FSM to IDLE.
  - Synchronizer flops cleared to 0.
  - All outputs go to 0: y, chg, busy, done, ovr.
  - No partial sweep resumes after reset.

## Timing
- Tick is combinationally high in cycle T.
- Channel k is processed in cycle T+1+k.
- Its updated y/chg are visible from cycle T+2+k.
- `busy`=1 in cycles T+1..T+N. `done`=1 in cycle T+N only.
- Consecutive ticks are exactly DIV cycles apart while `en`=1.
- Edge detection: a stable level change on `i[k]` first seen on sweep 1 (Z0→Z1) is accepted into E0 on sweep THR+3. `y[k]` rises at sweep THR+4.
  - THR=9: y rises on the 13th sweep.
  - Falling edge: symmetric.
- A glitch returning to the old level while in Z1/E1 with cnt ≤ THR aborts the change. cnt is cleared on the next step.

## Test plan
- **Reset values:** assert rst_n=0 for 3 cycles, then release with en=0 → y=0, chg=0, busy=0, done=0, ovr=0; no tick for 200 cycles.
- **Sweep timing:** N=4, DIV=8, en=1 from reset → tick every 8 cycles. busy is high 4 cycles starting 1 cycle after each tick. done is high on the 4th busy cycle.
- **Stable rise on ch2:** THR=9, i[2] held at 1 → y[2] rises, with a single chg[2] pulse, in the cycle after ch2 is processed on the 13th sweep. The other channels' y stays 0.
- **Glitch rejection:** i[1] high for 5 sweeps, then low → y[1] stays 0 and chg[1] never asserts. Repeat from y=1 with a 5-sweep low pulse → y[1] stays 1.
- **Overrun:** N=4, DIV=3 → ovr=1 after the first tick that lands inside a sweep, and stays 1. Every channel is still processed once per completed sweep.
- **Disruptions:**
  - Drop en mid-sweep: the sweep finishes and pre freezes. Re-enabling resumes from the frozen pre.
  - Assert rst_n=0 mid-sweep: all contexts return to Z0, y=0, busy=0 on the next edge.

Source files
------------

// File: rtl/filt_sched_if.sv
// rtl/filt_sched_if.sv - raw channel inputs and filtered level/event outputs of filt_sched
interface filt_sched_if #(
  parameter int N = 4
);
  logic         en;
  logic [N-1:0] i;
  logic [N-1:0] y;
  logic [N-1:0] chg;
  logic         busy;
  logic         done;
  logic         ovr;

  modport master (output en, i, input y, chg, busy, done, ovr);
  modport slave  (input en, i, output y, chg, busy, done, ovr);
endinterface

// File: rtl/filt_sched.sv
// rtl/filt_sched.sv - one glitch-filter engine time-shared over N channels, one channel per clock per tick
module filt_sched #(
  parameter int N   = 4,
  parameter int DIV = 100,
  parameter int THR = 9
) (
  input logic        clk,
  input logic        rst_n,
  filt_sched_if.slave bus
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, SCAN} state_t;
  typedef enum logic [1:0] {Z0 = 2'd0, Z1 = 2'd1, E0 = 2'd2, E1 = 2'd3} fst_t;

  state_t       state, state_nx;
  logic [CW-1:0] ch, ch_nx;
  logic [PW-1:0] pre;
  logic [N-1:0]  s1, is, y_q, chg_q;
  logic          ovr_q;
  fst_t          fst [N];
  logic [3:0]    cnt [N];

  logic tick, last;
  assign tick = bus.en && (pre == PW'(DIV - 1));
  assign last = (ch == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ch    <= '0;
    end else begin
      state <= state_nx;
      ch    <= ch_nx;
    end
  end

  // Once a sweep starts it runs to the last channel regardless of en.
  always_comb begin
    state_nx = state;
    ch_nx    = ch;
    case (state)
      IDLE: if (tick) begin
        state_nx = SCAN;
        ch_nx    = '0;
      end
      SCAN: if (last) begin
        state_nx = IDLE;
        ch_nx    = '0;
      end else begin
        ch_nx = ch + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  fst_t       f_old, f_new;
  logic [3:0] c_old, c_new;
  logic       s_k, y_old, y_new;

  // cnt only survives a step that stays in Z1/E1; expiry beats the input level.
  always_comb begin
    f_old = fst[ch];
    c_old = cnt[ch];
    s_k   = is[ch];
    y_old = y_q[ch];
    f_new = f_old;
    c_new = '0;
    y_new = y_old;
    case (f_old)
      Z0: begin
        y_new = 1'b0;
        if (s_k) f_new = Z1;
      end
      Z1: begin
        if (c_old > 4'(THR)) f_new = E0;
        else if (!s_k)       f_new = Z0;
        else                 c_new = c_old + 1'b1;
      end
      E0: begin
        y_new = 1'b1;
        if (!s_k) f_new = E1;
      end
      E1: begin
        if (c_old > 4'(THR)) f_new = Z0;
        else if (s_k)        f_new = E0;
        else                 c_new = c_old + 1'b1;
      end
      default: f_new = Z0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= '0;
      is    <= '0;
      pre   <= '0;
      ovr_q <= 1'b0;
      y_q   <= '0;
      chg_q <= '0;
      for (int k = 0; k < N; k++) begin
        fst[k] <= Z0;
        cnt[k] <= '0;
      end
    end else begin
      s1 <= bus.i;
      is <= s1;
      if (bus.en) pre <= (pre == PW'(DIV - 1)) ? '0 : pre + 1'b1;
      if (tick && state == SCAN) ovr_q <= 1'b1;
      chg_q <= '0;
      if (state == SCAN) begin
        fst[ch]   <= f_new;
        cnt[ch]   <= c_new;
        y_q[ch]   <= y_new;
        chg_q[ch] <= y_new ^ y_old;
      end
    end
  end

  assign bus.y    = y_q;
  assign bus.chg  = chg_q;
  assign bus.ovr  = ovr_q;
  assign bus.busy = (state == SCAN);
  assign bus.done = (state == SCAN) && last;
endmodule

// File: tb/tb_filt_sched.sv
// tb/tb_filt_sched.sv - bench for filt_sched: two instances (DIV=8/THR=9 and overrunning DIV=3/THR=1) against a sweep-queue model
module tb_filt_sched;
  localparam int NCH  = 4;
  localparam int DIVA = 8;
  localparam int THRA = 9;
  localparam int DIVB = 3;
  localparam int THRB = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  filt_sched_if #(.N(NCH)) bus0 ();
  filt_sched_if #(.N(NCH)) bus1 ();

  filt_sched #(.N(NCH), .DIV(DIVA), .THR(THRA)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  filt_sched #(.N(NCH), .DIV(DIVB), .THR(THRB)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic [3:0] dy [2], dchg [2];
  logic       dbusy [2], ddone [2], dovr [2];
  assign dy[0] = bus0.y;       assign dy[1] = bus1.y;
  assign dchg[0] = bus0.chg;   assign dchg[1] = bus1.chg;
  assign dbusy[0] = bus0.busy; assign dbusy[1] = bus1.busy;
  assign ddone[0] = bus0.done; assign ddone[1] = bus1.done;
  assign dovr[0] = bus0.ovr;   assign dovr[1] = bus1.ovr;

  bit       en_v;
  bit [3:0] i_v;
  int checks = 0;
  int errors = 0;

  // Model: a tick queues a sweep of NCH channel visits; each channel keeps its
  // accepted level and the run length of sweeps that disagreed with it.
  int       pre_m [2], pend [2];
  int       r_m [2][NCH];
  bit [3:0] s1_m [2], is_m [2], a_m [2], y_m [2], chg_m [2];
  bit       ovr_m [2], busy_m [2], done_m [2];

  task automatic model_edge(int d);
    int  div, thr, k;
    bit  tick;
    div = d ? DIVB : DIVA;
    thr = d ? THRB : THRA;
    if (!rst_n) begin
      pre_m[d] = 0; pend[d] = 0; ovr_m[d] = 0;
      s1_m[d] = 0; is_m[d] = 0; a_m[d] = 0; y_m[d] = 0; chg_m[d] = 0;
      for (int j = 0; j < NCH; j++) r_m[d][j] = 0;
    end else begin
      tick = en_v && (pre_m[d] == div - 1);
      if (en_v) pre_m[d] = (pre_m[d] + 1) % div;
      chg_m[d] = 0;
      if (pend[d] > 0) begin
        k = NCH - pend[d];
        chg_m[d][k] = (y_m[d][k] != a_m[d][k]);
        y_m[d][k] = a_m[d][k];
        if (r_m[d][k] == thr + 2) begin
          a_m[d][k] = !a_m[d][k];
          r_m[d][k] = 0;
        end else if (is_m[d][k] != a_m[d][k]) r_m[d][k]++;
        else r_m[d][k] = 0;
        if (tick) ovr_m[d] = 1;
        pend[d]--;
      end else if (tick) pend[d] = NCH;
      is_m[d] = s1_m[d];
      s1_m[d] = i_v;
    end
    busy_m[d] = (pend[d] > 0);
    done_m[d] = (pend[d] == 1);
  endtask

  always @(posedge clk) for (int d = 0; d < 2; d++) model_edge(d);

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check($sformatf("y%0d", d), 32'(dy[d]), 32'(y_m[d]));
        check($sformatf("chg%0d", d), 32'(dchg[d]), 32'(chg_m[d]));
        check($sformatf("busy%0d", d), 32'(dbusy[d]), 32'(busy_m[d]));
        check($sformatf("done%0d", d), 32'(ddone[d]), 32'(done_m[d]));
        check($sformatf("ovr%0d", d), 32'(dovr[d]), 32'(ovr_m[d]));
      end
    end
  endtask

  task automatic set_in(bit e, bit [3:0] v);
    en_v = e; i_v = v;
    bus0.en = e; bus1.en = e;
    bus0.i = v;  bus1.i = v;
  endtask

  task automatic wait_busy(string tag);
    int n = 0;
    while (!dbusy[0] && n < 50) begin
      cyc(1);
      n++;
    end
    check(tag, 32'(dbusy[0]), 32'd1);
  endtask

  int nchg;
  int nbusy;

  initial begin
    set_in(0, 4'h0);
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    nbusy = 0;
    for (int c = 0; c < 200; c++) begin
      cyc(1);
      if (dbusy[0] || dbusy[1]) nbusy++;
    end
    check("no_tick_en0", 32'(nbusy), 32'd0);

    set_in(1, 4'h0);
    cyc(40);

    set_in(1, 4'b0100);
    nchg = 0;
    for (int c = 0; c < 130; c++) begin
      cyc(1);
      if (dchg[0][2]) nchg++;
    end
    check("rise_ch2_pulses", 32'(nchg), 32'd1);
    check("rise_ch2_y", 32'(dy[0]), 32'b0100);

    set_in(1, 4'b0110);
    cyc(40);
    set_in(1, 4'b0100);
    cyc(120);
    check("glitch_hi_y1", 32'(dy[0][1]), 32'd0);
    set_in(1, 4'b0110);
    cyc(130);
    check("accept_y1", 32'(dy[0][1]), 32'd1);
    set_in(1, 4'b0100);
    cyc(40);
    set_in(1, 4'b0110);
    cyc(130);
    check("glitch_lo_y1", 32'(dy[0][1]), 32'd1);

    wait_busy("busy_before_endrop");
    set_in(0, i_v);
    cyc(30);
    set_in(1, i_v);
    cyc(30);

    for (int s = 0; s < 40; s++) begin
      set_in($urandom_range(0, 7) != 0, 4'($urandom));
      cyc($urandom_range(1, 150));
    end

    check("ovr_sticky", 32'(dovr[1]), 32'd1);
    wait_busy("busy_before_rst");
    rst_n = 1'b0;
    cyc(1);
    check("rst_y", 32'(dy[0]), 32'd0);
    check("rst_busy", 32'(dbusy[0]), 32'd0);
    check("rst_ovr", 32'(dovr[1]), 32'd0);
    rst_n = 1'b1;
    set_in(1, 4'hF);
    cyc(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
